if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch front end.
- Drives a decoupled, variable-latency instruction memory over a valid/ready request port and a valid-only response port.
- Buffers fetched instructions and their PCs in a DEPTH-entry FIFO.
- Presents them to ID with a valid/ready handshake; a branch/jump redirect from EX flushes the buffer and squashes in-flight responses.

Parameters:
- XLEN, 32, width of PC and address paths.
- ILEN, 32, instruction width.
- DEPTH, 4, fetch-queue entries; power of two, ≥2.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- redirect_valid  input  1  EX branch/jump taken; flush and reload PC
- redirect_pc  input  XLEN  new fetch PC
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  fetch address
- imem_rsp_valid  input  1  returned instruction valid; exactly one response per accepted request, in order, ≥1 cycle after acceptance
- imem_rsp_data  input  ILEN  returned instruction
- id_valid  output  1  head entry valid
- id_ready  input  1  ID consumes head (low = load-use stall)
- id_instr  output  ILEN  head instruction
- id_pc  output  XLEN  head PC
- id_pc_plus4  output  XLEN  head PC + 4, modulo 2^XLEN
- q_count  output  clog2(DEPTH)+1  occupancy, for debug/perf counters

Behaviour:
- Reset (async, rst_n low):
  - fetch_pc = RESET_PC; FSM = IDLE; count = 0; rd/wr pointers = 0.
  - imem_req_valid = 0, id_valid = 0, q_count = 0.
  - id_instr/id_pc/id_pc_plus4 = 0.
- Reset mid-transaction abandons any outstanding request. The bench must not deliver its response after reset release.
- FSM states:
  - IDLE: no request outstanding.
  - WAIT: one live request outstanding.
  - WAIT_STALE: one squashed request outstanding.
- imem_req_valid = (state==IDLE) && !redirect_valid && (count < DEPTH). imem_req_addr = fetch_pc.
- Request accepted (req_valid && req_ready):
  - req_pc <= fetch_pc; fetch_pc <= fetch_pc + 4 (wraps); IDLE -> WAIT.
- Response in WAIT:
  - If !redirect_valid: push {req_pc, imem_rsp_data} at wr pointer; WAIT -> IDLE.
  - With redirect_valid the same cycle: response dropped; -> IDLE.
- Response in WAIT_STALE: dropped, no push; -> IDLE.
- Redirect (redirect_valid=1), highest priority:
  - fetch_pc <= redirect_pc; count and pointers cleared; pop ignored.
  - WAIT -> WAIT_STALE; IDLE stays IDLE (no request issued this cycle); WAIT_STALE stays WAIT_STALE.
  - Next request issues in the first IDLE cycle after redirect deassertion, or the same cycle if redirect was a single pulse and the state is IDLE.
- No overflow: a request is only issued when count < DEPTH, and at most one is outstanding. A push therefore always has room, even with no pop.
- Pop: id_valid && id_ready && !redirect_valid advances rd pointer.
- Simultaneous push and pop: count unchanged. Push into empty queue: id_valid rises the next cycle (one-cycle minimum rsp-to-ID latency; no bypass).
- id_valid = (count != 0). Head fields come from rd pointer. Outputs are held stable while id_valid && !id_ready.
- Pointers wrap modulo DEPTH.
- Steady-state throughput: one instruction per 2 cycles with 1-cycle memory (single outstanding), by design.

Decomposition:
- Shared package `rv_pipe_pkg`:
  - fetch FSM state enum (IDLE, WAIT, WAIT_STALE)
  - INSTR_NOP constant 32'h00000013
  - typedef fetch_entry_t {pc, instr}
- Sub-module `sync_fifo` (parametrised WIDTH, DEPTH; push/pop/clear, count, head).
- if_fetch_queue holds the FSM, PC register and request/response control, and instantiates sync_fifo with WIDTH = XLEN+ILEN.

Test Plan:
- Reset, then rst_n high; memory returns 1-cycle responses, id_ready=1 -> requests at addr 0x0, 0x4, 0x8; ID sees pc 0x0/pc_plus4 0x4, then 0x4, 0x8 in order, each instr matching memory contents.
- id_ready=0 for 20 cycles -> exactly DEPTH=4 pushes; imem_req_valid held 0 with q_count=4 and head (pc 0x0) stable; release -> 4 pops in order, fetching resumes at 0x10.
- Redirect to 0x100 while request for 0x8 is outstanding (rsp 3 cycles later) -> queue empties next cycle; 0x8 response dropped; next request addr 0x100; ID next sees pc 0x100.
- Redirect in same cycle as response and as id_ready pop -> nothing pushed or popped; q_count=0; next fetch at redirect_pc.
- imem_req_ready low 5 cycles -> req_valid/addr held stable; no duplicate request; single response pushed once.
- fetch_pc=0xFFFFFFFC -> pc_plus4 reads 0x0 and the next request addr is 0x0 (wrap).

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared fetch-pipeline types and constants
package rv_pipe_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, WAIT_STALE} fetch_state_t;
  localparam logic [31:0] INSTR_NOP = 32'h00000013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular buffer with push/pop/clear, count and head
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (clear) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr] <= din;
  end
  assign head = mem[rd];
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: single-outstanding instruction fetch FSM feeding a FIFO to ID, flushed on redirect
module if_fetch_queue
  import rv_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [ILEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [CW-1:0]   q_count
);
  fetch_state_t state, state_n;
  logic [XLEN-1:0] fetch_pc, req_pc;
  logic [XLEN+ILEN-1:0] head;
  logic req_fire, push, pop;
  assign imem_req_valid = rst_n && state == IDLE && !redirect_valid && q_count < CW'(DEPTH);
  assign imem_req_addr = fetch_pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign push = state == WAIT && imem_rsp_valid && !redirect_valid;
  assign pop = id_valid && id_ready && !redirect_valid;
  assign id_valid = q_count != '0;
  assign id_pc = id_valid ? head[XLEN+ILEN-1:ILEN] : '0;
  assign id_instr = id_valid ? head[ILEN-1:0] : '0;
  assign id_pc_plus4 = id_valid ? id_pc + XLEN'(4) : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:       state_n = req_fire ? WAIT : IDLE;
      WAIT:       state_n = imem_rsp_valid ? IDLE : redirect_valid ? WAIT_STALE : WAIT;
      WAIT_STALE: state_n = imem_rsp_valid ? IDLE : WAIT_STALE;
      default:    state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      req_pc <= '0;
    end else begin
      state <= state_n;
      fetch_pc <= redirect_valid ? redirect_pc : req_fire ? fetch_pc + XLEN'(4) : fetch_pc;
      if (req_fire) req_pc <= fetch_pc;
    end
  end
  sync_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect_valid),
    .push  (push),
    .din   ({req_pc, imem_rsp_data}),
    .pop   (pop),
    .count (q_count),
    .head  (head)
  );
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed vector table plus hand-written corner sequences with a simple memory model
module tb_if_fetch_queue;
  logic clk = 0;
  logic rst_n = 0;
  logic redirect_valid = 0;
  logic [31:0] redirect_pc = 0;
  logic imem_req_valid, imem_req_ready = 0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 0;
  logic [31:0] imem_rsp_data = 0;
  logic id_valid, id_ready = 0;
  logic [31:0] id_instr, id_pc, id_pc_plus4;
  logic [2:0] q_count;
  int pass_cnt = 0, total_cnt = 0, fires = 0, f0;
  logic mem_on = 0, pend = 0;
  logic [31:0] pend_addr;
  int lat = 1, lat_left = 0;

  typedef struct {
    logic rsp_v; logic [31:0] rsp_d; logic id_rdy; logic rq_rdy;
    logic e_req_v; logic [31:0] e_addr; logic e_id_v; logic [31:0] e_pc;
    logic [31:0] e_instr; logic [31:0] e_p4; logic [2:0] e_q;
  } vec_t;
  vec_t tv [7];

  if_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .q_count(q_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    if (mem_on) begin
      if (pend && lat_left == 0) begin
        imem_rsp_valid = 1;
        imem_rsp_data = mem_f(pend_addr);
        pend = 0;
      end else begin
        imem_rsp_valid = 0;
        if (pend) lat_left--;
      end
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      fires++;
      pend = 1;
      pend_addr = imem_req_addr;
      lat_left = lat - 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 0;
    redirect_valid = 0;
    imem_req_ready = 0;
    imem_rsp_valid = 0;
    id_ready = 0;
    pend = 0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_id_valid", 32'(id_valid), 0);
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_id_pc_plus4", id_pc_plus4, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    tv[0] = '{0, 32'h0,        1, 1, 1, 32'h0, 0, 32'h0, 32'h0,        32'h0, 0};
    tv[1] = '{1, 32'h5A5A5A5A, 1, 1, 0, 32'h4, 0, 32'h0, 32'h0,        32'h0, 0};
    tv[2] = '{0, 32'h0,        1, 1, 1, 32'h4, 1, 32'h0, 32'h5A5A5A5A, 32'h4, 1};
    tv[3] = '{1, 32'h5A5A5A5E, 1, 1, 0, 32'h8, 0, 32'h0, 32'h0,        32'h0, 0};
    tv[4] = '{0, 32'h0,        1, 1, 1, 32'h8, 1, 32'h4, 32'h5A5A5A5E, 32'h8, 1};
    tv[5] = '{1, 32'h5A5A5A52, 1, 1, 0, 32'hC, 0, 32'h0, 32'h0,        32'h0, 0};
    tv[6] = '{0, 32'h0,        1, 0, 1, 32'hC, 1, 32'h8, 32'h5A5A5A52, 32'hC, 1};
    @(negedge clk);
    do_reset();
    mem_on = 0;
    for (int i = 0; i < 7; i++) begin
      imem_rsp_valid = tv[i].rsp_v;
      imem_rsp_data = tv[i].rsp_d;
      id_ready = tv[i].id_rdy;
      imem_req_ready = tv[i].rq_rdy;
      #1;
      chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(tv[i].e_req_v));
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, tv[i].e_addr);
      chk($sformatf("v%0d_id_valid", i), 32'(id_valid), 32'(tv[i].e_id_v));
      chk($sformatf("v%0d_id_pc", i), id_pc, tv[i].e_pc);
      chk($sformatf("v%0d_id_instr", i), id_instr, tv[i].e_instr);
      chk($sformatf("v%0d_pc_plus4", i), id_pc_plus4, tv[i].e_p4);
      chk($sformatf("v%0d_q_count", i), 32'(q_count), 32'(tv[i].e_q));
      tick();
    end

    // Backpressure: queue fills to DEPTH, then drains in order
    do_reset();
    mem_on = 1; lat = 1; imem_req_ready = 1; id_ready = 0;
    f0 = fires;
    repeat (20) tick();
    #1;
    chk("full_fires", 32'(fires - f0), 4);
    chk("full_q_count", 32'(q_count), 4);
    chk("full_req_valid", 32'(imem_req_valid), 0);
    chk("full_head_pc", id_pc, 0);
    chk("full_head_instr", id_instr, 32'h5A5A5A5A);
    id_ready = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("drain%0d_id_valid", i), 32'(id_valid), 1);
      chk($sformatf("drain%0d_pc", i), id_pc, 32'(4 * i));
      chk($sformatf("drain%0d_instr", i), id_instr, mem_f(32'(4 * i)));
      if (i == 1) begin
        chk("resume_req_valid", 32'(imem_req_valid), 1);
        chk("resume_req_addr", imem_req_addr, 32'h10);
      end
      tick();
    end

    // Redirect with a live request outstanding (3-cycle response)
    do_reset();
    mem_on = 1; lat = 1; imem_req_ready = 1; id_ready = 0;
    repeat (4) tick();
    lat = 3;
    #1;
    chk("rd_req_addr8", imem_req_addr, 32'h8);
    tick();
    redirect_valid = 1; redirect_pc = 32'h100;
    #1;
    chk("rd_pre_q_count", 32'(q_count), 2);
    chk("rd_req_valid_during", 32'(imem_req_valid), 0);
    tick();
    redirect_valid = 0;
    #1;
    chk("rd_flush_q_count", 32'(q_count), 0);
    chk("rd_flush_id_valid", 32'(id_valid), 0);
    chk("rd_stale_req_valid", 32'(imem_req_valid), 0);
    tick();
    #1;
    chk("rd_stale_req_valid2", 32'(imem_req_valid), 0);
    tick();
    lat = 1;
    #1;
    chk("rd_drop_q_count", 32'(q_count), 0);
    chk("rd_new_req_valid", 32'(imem_req_valid), 1);
    chk("rd_new_req_addr", imem_req_addr, 32'h100);
    tick();
    tick();
    #1;
    chk("rd_id_pc", id_pc, 32'h100);
    chk("rd_id_instr", id_instr, 32'h5A5A5B5A);
    chk("rd_pc_plus4", id_pc_plus4, 32'h104);

    // Redirect coinciding with a response and a pop
    do_reset();
    mem_on = 1; lat = 1; imem_req_ready = 1; id_ready = 0;
    repeat (3) tick();
    redirect_valid = 1; redirect_pc = 32'h200; id_ready = 1;
    #1;
    chk("co_head_pc", id_pc, 32'h0);
    tick();
    redirect_valid = 0; id_ready = 0;
    #1;
    chk("co_q_count", 32'(q_count), 0);
    chk("co_id_valid", 32'(id_valid), 0);
    chk("co_req_valid", 32'(imem_req_valid), 1);
    chk("co_req_addr", imem_req_addr, 32'h200);
    tick();
    tick();
    #1;
    chk("co_id_pc", id_pc, 32'h200);
    chk("co_q_count2", 32'(q_count), 1);

    // Memory not ready: request held stable, issued once
    do_reset();
    mem_on = 1; lat = 1; imem_req_ready = 0; id_ready = 0;
    f0 = fires;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("hold%0d_req_valid", i), 32'(imem_req_valid), 1);
      chk($sformatf("hold%0d_req_addr", i), imem_req_addr, 32'h0);
      tick();
    end
    imem_req_ready = 1;
    tick();
    imem_req_ready = 0;
    repeat (4) tick();
    #1;
    chk("hold_fires", 32'(fires - f0), 1);
    chk("hold_q_count", 32'(q_count), 1);
    chk("hold_next_addr", imem_req_addr, 32'h4);

    // PC wrap at the top of the address space
    do_reset();
    mem_on = 1; lat = 1; imem_req_ready = 0; id_ready = 0;
    redirect_valid = 1; redirect_pc = 32'hFFFFFFFC;
    #1;
    chk("wrap_req_valid_redir", 32'(imem_req_valid), 0);
    tick();
    redirect_valid = 0; imem_req_ready = 1;
    #1;
    chk("wrap_req_valid", 32'(imem_req_valid), 1);
    chk("wrap_req_addr", imem_req_addr, 32'hFFFFFFFC);
    tick();
    imem_req_ready = 0;
    tick();
    #1;
    chk("wrap_id_pc", id_pc, 32'hFFFFFFFC);
    chk("wrap_pc_plus4", id_pc_plus4, 32'h0);
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    chk("wrap_next_valid", 32'(imem_req_valid), 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
